qos_flow_ctrl_fsm: RTL and testbench
====================================

Name: qos_flow_ctrl_fsm

Overview:
- Parametrised flow-control sequencer for the QoS module; generalises the 4-channel pause/continue FSM to NUM_CH channels.
- Sits between the per-VC FIFO status flags and the link-layer DLLP generator.
- Issues independent per-channel pause/continue strobes, so no combined pause+continue state is needed.
- Adds tracking of paused channels, an idle timeout back to IDLE, an error-entry counter and a selectable error-recovery mode.

Parameters:
NUM_CH, 4, number of FIFO channels (1..16)
IDLE_TIMEOUT, 16, consecutive all-empty cycles in ACTIVE before returning to IDLE (>=1)
ERR_MODE, 0, 0 = ERROR exits only via reset; 1 = error_clear also exits to IDLE
ERR_CNT_W, 8, width of saturating error-entry counter

Ports:
CLK  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
set_init  in  1  hold in INIT while high
error_clear  in  1  ERROR exit request (ERR_MODE=1 only)
empty  in  NUM_CH  per-channel FIFO empty
full  in  NUM_CH  per-channel FIFO full
pause_fifos  in  NUM_CH  per-channel pause request level
continue_fifos  in  NUM_CH  per-channel continue request level
init  out  1  high while in INIT with set_init high
idle  out  1  high while in IDLE with all empty
pause_stb  out  NUM_CH  one-cycle pause strobe per channel
continue_stb  out  NUM_CH  one-cycle continue strobe per channel
paused  out  NUM_CH  channel currently paused
error_full  out  NUM_CH  full channels latched in ERROR (sticky OR)
err_count  out  ERR_CNT_W  saturating count of ERROR entries
state_o  out  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

Behaviour:
- All outputs are registered.
- Reset asserted: state=RESET, all outputs 0, edge-history registers (pause_q, continue_q) 0, timeout counter 0. This holds mid-operation too, asynchronously.
- RESET: the first edge after reset deasserts moves to INIT.
- INIT: init=1 registered on each edge where set_init=1 (stay). When set_init=0, go to IDLE with init=0.
- IDLE: idle=1 while &empty. If any empty bit is 0, go to ACTIVE and clear the timeout counter.
- pause_q and continue_q sample their inputs every edge in every non-reset state. Edges are therefore detected only for transitions that occur while in ACTIVE; a level already high on ACTIVE entry produces no strobe.
- ACTIVE, evaluated per edge in this priority:
  1. |full: go to ERROR; error_full<=full; err_count+=1 (saturate at all-ones); no strobes issued this edge.
  2. Per channel i, pause rise (pause_fifos[i] & ~pause_q[i]): pause_stb[i]<=1, paused[i]<=1.
  3. Per channel i, continue rise: continue_stb[i]<=1, paused[i]<=0, unless a pause rise on the same channel occurs this edge. In that case pause wins, continue is dropped and paused[i]=1.
  4. Different channels may strobe pause and continue in the same cycle.
  5. Strobes last exactly one cycle; a held level does not re-strobe.
  6. Timeout counter increments when &empty and no strobe is issued this edge; otherwise it clears. When it reaches IDLE_TIMEOUT, go to IDLE and clear the counter. paused is preserved.
- ERROR: error_full<=error_full|full each edge; strobes 0.
  - ERR_MODE=0: remain until reset.
  - ERR_MODE=1: error_clear=1 goes to IDLE, clears error_full, paused, pause_q and continue_q. err_count is kept.
- Undefined state encodings recover to INIT on the next edge.
- Width rules: all channel vectors are NUM_CH bits. err_count saturates and does not wrap.

Test Plan:
- Reset with set_init=1 for 3 cycles, then set_init=0, empty=4'hF, then empty=4'hE -> state_o sequence 0,1,1,1,2,3. init=1 for 3 cycles, idle=1 in IDLE, idle=0 in ACTIVE.
- ACTIVE, pause_fifos 0->4'b0101 held 5 cycles -> pause_stb=4'b0101 for exactly 1 cycle, paused=4'b0101. Then continue_fifos 0->4'b0001 -> continue_stb=4'b0001, paused=4'b0100.
- ACTIVE, same edge pause_fifos[2] and continue_fifos[2] rise, continue_fifos[1] rises -> pause_stb=4'b0100, continue_stb=4'b0010, paused[2]=1.
- ACTIVE, full=4'b1000 with a simultaneous pause rise -> state_o=4, error_full=4'b1000, no strobe, err_count=1. Then full=4'b0010 -> error_full=4'b1010.
- ERR_MODE=1, error_clear pulse in ERROR -> state_o=2, error_full=0, paused=0, err_count=1. ERR_MODE=0, same stimulus -> stays in ERROR until reset.
- ACTIVE with empty=4'hF and no request edges for IDLE_TIMEOUT=16 cycles -> IDLE on the 16th edge. A pause edge at cycle 10 restarts the count.

Source files
------------

// File: rtl/qos_flow_ctrl_fsm_if.sv
// Signal bundle between the QoS flow-control sequencer and its FIFO-status /
// DLLP-generator neighbours. The sequencer side uses the master modport.
interface qos_flow_ctrl_fsm_if #(
   parameter int NUM_CH    = 4,
   parameter int ERR_CNT_W = 8
);
   logic                 set_init;
   logic                 error_clear;
   logic [NUM_CH-1:0]    empty;
   logic [NUM_CH-1:0]    full;
   logic [NUM_CH-1:0]    pause_fifos;
   logic [NUM_CH-1:0]    continue_fifos;
   logic                 init;
   logic                 idle;
   logic [NUM_CH-1:0]    pause_stb;
   logic [NUM_CH-1:0]    continue_stb;
   logic [NUM_CH-1:0]    paused;
   logic [NUM_CH-1:0]    error_full;
   logic [ERR_CNT_W-1:0] err_count;
   logic [2:0]           state_o;

   // Handshake: request inputs are levels; pause_stb/continue_stb are single-cycle
   // strobes with no back-pressure -- the consumer must accept them on the cycle
   // they are high. All sequencer outputs are registered.
   modport master (
      input  set_init, error_clear, empty, full, pause_fifos, continue_fifos,
      output init, idle, pause_stb, continue_stb, paused, error_full, err_count, state_o
   );

   modport slave (
      output set_init, error_clear, empty, full, pause_fifos, continue_fifos,
      input  init, idle, pause_stb, continue_stb, paused, error_full, err_count, state_o
   );
endinterface

// File: rtl/qos_flow_ctrl_fsm.sv
// Per-channel pause/continue sequencer: edge-detects request levels in ACTIVE,
// tracks paused channels, times out back to IDLE and latches full errors.
module qos_flow_ctrl_fsm #(
   parameter int NUM_CH       = 4,
   parameter int IDLE_TIMEOUT = 16,
   parameter int ERR_MODE     = 0,
   parameter int ERR_CNT_W    = 8
) (
   input  logic CLK,
   input  logic reset,
   qos_flow_ctrl_fsm_if.master qif
);
   localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 init_q, init_d;
   logic                 idle_q, idle_d;
   logic [NUM_CH-1:0]    pause_stb_q, pause_stb_d;
   logic [NUM_CH-1:0]    continue_stb_q, continue_stb_d;
   logic [NUM_CH-1:0]    paused_q, paused_d;
   logic [NUM_CH-1:0]    error_full_q, error_full_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic [NUM_CH-1:0]    pause_q, pause_d;
   logic [NUM_CH-1:0]    continue_q, continue_d;
   logic [TO_W-1:0]      to_q, to_d;

   logic [NUM_CH-1:0]    p_rise;
   logic [NUM_CH-1:0]    c_rise;
   logic [TO_W-1:0]      to_inc;
   logic                 all_empty;

   // A pause rise on a channel suppresses a simultaneous continue rise there.
   assign p_rise    = qif.pause_fifos & ~pause_q;
   assign c_rise    = qif.continue_fifos & ~continue_q & ~p_rise;
   assign to_inc    = to_q + TO_W'(1);
   assign all_empty = &qif.empty;

   always_comb begin
      state_d        = state_q;
      init_d         = 1'b0;
      idle_d         = 1'b0;
      pause_stb_d    = '0;
      continue_stb_d = '0;
      paused_d       = paused_q;
      error_full_d   = error_full_q;
      err_count_d    = err_count_q;
      pause_d        = qif.pause_fifos;
      continue_d     = qif.continue_fifos;
      to_d           = to_q;

      case (state_q)
         ST_RESET: begin
            state_d = ST_INIT;
            init_d  = qif.set_init;
         end
         ST_INIT: begin
            if (qif.set_init) begin
               init_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               idle_d  = all_empty;
            end
         end
         ST_IDLE: begin
            if (all_empty) begin
               idle_d = 1'b1;
            end else begin
               state_d = ST_ACTIVE;
               to_d    = '0;
            end
         end
         ST_ACTIVE: begin
            if (|qif.full) begin
               state_d      = ST_ERROR;
               error_full_d = qif.full;
               to_d         = '0;
               if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
            end else begin
               pause_stb_d    = p_rise;
               continue_stb_d = c_rise;
               paused_d       = (paused_q | p_rise) & ~c_rise;
               if (all_empty && (p_rise == '0) && (c_rise == '0)) begin
                  if (to_inc == TO_W'(IDLE_TIMEOUT)) begin
                     state_d = ST_IDLE;
                     to_d    = '0;
                     idle_d  = 1'b1;
                  end else begin
                     to_d = to_inc;
                  end
               end else begin
                  to_d = '0;
               end
            end
         end
         ST_ERROR: begin
            error_full_d = error_full_q | qif.full;
            if ((ERR_MODE == 1) && qif.error_clear) begin
               state_d      = ST_IDLE;
               error_full_d = '0;
               paused_d     = '0;
               pause_d      = '0;
               continue_d   = '0;
               idle_d       = all_empty;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q        <= ST_RESET;
         init_q         <= 1'b0;
         idle_q         <= 1'b0;
         pause_stb_q    <= '0;
         continue_stb_q <= '0;
         paused_q       <= '0;
         error_full_q   <= '0;
         err_count_q    <= '0;
         pause_q        <= '0;
         continue_q     <= '0;
         to_q           <= '0;
      end else begin
         state_q        <= state_d;
         init_q         <= init_d;
         idle_q         <= idle_d;
         pause_stb_q    <= pause_stb_d;
         continue_stb_q <= continue_stb_d;
         paused_q       <= paused_d;
         error_full_q   <= error_full_d;
         err_count_q    <= err_count_d;
         pause_q        <= pause_d;
         continue_q     <= continue_d;
         to_q           <= to_d;
      end
   end

   assign qif.init         = init_q;
   assign qif.idle         = idle_q;
   assign qif.pause_stb    = pause_stb_q;
   assign qif.continue_stb = continue_stb_q;
   assign qif.paused       = paused_q;
   assign qif.error_full   = error_full_q;
   assign qif.err_count    = err_count_q;
   assign qif.state_o      = state_q;
endmodule

// File: tb/tb_qos_flow_ctrl_fsm.sv
// Bench for qos_flow_ctrl_fsm: two instances (ERR_MODE 0 and 1) share stimulus
// and are compared against a per-edge reference model plus directed vectors.
module tb_qos_flow_ctrl_fsm;
   localparam int NCH = 4;
   localparam int TO  = 16;
   localparam int ECW = 3;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   qos_flow_ctrl_fsm_if #(.NUM_CH(NCH), .ERR_CNT_W(ECW)) q0 ();
   qos_flow_ctrl_fsm_if #(.NUM_CH(NCH), .ERR_CNT_W(ECW)) q1 ();

   qos_flow_ctrl_fsm #(.NUM_CH(NCH), .IDLE_TIMEOUT(TO), .ERR_MODE(0), .ERR_CNT_W(ECW))
      u0 (.CLK(CLK), .reset(reset), .qif(q0));
   qos_flow_ctrl_fsm #(.NUM_CH(NCH), .IDLE_TIMEOUT(TO), .ERR_MODE(1), .ERR_CNT_W(ECW))
      u1 (.CLK(CLK), .reset(reset), .qif(q1));

   logic       si, ec;
   logic [3:0] emp, ful, pf, cf;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state, index = ERR_MODE of the instance
   int         m_state[2];
   int         m_cnt[2];
   int         m_to[2];
   logic       m_init[2], m_idle[2];
   logic [3:0] m_pstb[2], m_cstb[2], m_paused[2], m_ef[2], m_pq[2], m_cq[2];

   typedef struct {
      logic       si;
      logic [3:0] emp, ful, pf, cf;
      logic [2:0] st;
      logic       ini, idl;
      logic [3:0] ps, cs, pd, ef;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(logic s, logic [3:0] e, logic [3:0] f, logic [3:0] p, logic [3:0] c,
                               logic [2:0] st, logic ini, logic idl, logic [3:0] ps,
                               logic [3:0] cs, logic [3:0] pd, logic [3:0] ef, logic [2:0] cnt);
      vec_t v;
      v.si = s; v.emp = e; v.ful = f; v.pf = p; v.cf = c;
      v.st = st; v.ini = ini; v.idl = idl; v.ps = ps; v.cs = cs; v.pd = pd; v.ef = ef; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      q0.set_init = si;  q1.set_init = si;
      q0.error_clear = ec; q1.error_clear = ec;
      q0.empty = emp; q1.empty = emp;
      q0.full = ful;  q1.full = ful;
      q0.pause_fifos = pf; q1.pause_fifos = pf;
      q0.continue_fifos = cf; q1.continue_fifos = cf;
   endtask

   task automatic model_edge(input int m);
      logic [3:0] opq, ocq;
      int mx;
      mx = (1 << ECW) - 1;
      if (reset) begin
         m_state[m] = 0; m_cnt[m] = 0; m_to[m] = 0; m_init[m] = 0; m_idle[m] = 0;
         m_pstb[m] = 0; m_cstb[m] = 0; m_paused[m] = 0; m_ef[m] = 0; m_pq[m] = 0; m_cq[m] = 0;
         return;
      end
      opq = m_pq[m]; ocq = m_cq[m];
      m_pq[m] = pf; m_cq[m] = cf;
      m_pstb[m] = 0; m_cstb[m] = 0; m_init[m] = 0; m_idle[m] = 0;
      case (m_state[m])
         0: begin m_state[m] = 1; m_init[m] = si; end
         1: if (si) m_init[m] = 1;
            else begin m_state[m] = 2; m_idle[m] = (emp == 4'hF); end
         2: if (emp == 4'hF) m_idle[m] = 1;
            else begin m_state[m] = 3; m_to[m] = 0; end
         3: if (ful != 0) begin
               m_state[m] = 4; m_ef[m] = ful;
               if (m_cnt[m] < mx) m_cnt[m]++;
            end else begin
               for (int i = 0; i < NCH; i++) begin
                  if (pf[i] && !opq[i]) begin m_pstb[m][i] = 1; m_paused[m][i] = 1; end
                  else if (cf[i] && !ocq[i]) begin m_cstb[m][i] = 1; m_paused[m][i] = 0; end
               end
               if (emp == 4'hF && m_pstb[m] == 0 && m_cstb[m] == 0) m_to[m]++;
               else m_to[m] = 0;
               if (m_to[m] == TO) begin m_state[m] = 2; m_to[m] = 0; m_idle[m] = 1; end
            end
         4: begin
            m_ef[m] = m_ef[m] | ful;
            if (m == 1 && ec) begin
               m_state[m] = 2; m_ef[m] = 0; m_paused[m] = 0; m_pq[m] = 0; m_cq[m] = 0;
               m_idle[m] = (emp == 4'hF);
            end
         end
         default: m_state[m] = 1;
      endcase
   endtask

   task automatic check_models();
      logic [2:0] st, cnt;
      logic       ini, idl;
      logic [3:0] ps, cs, pd, ef;
      for (int m = 0; m < 2; m++) begin
         if (m == 0) begin
            st = q0.state_o; cnt = q0.err_count; ini = q0.init; idl = q0.idle;
            ps = q0.pause_stb; cs = q0.continue_stb; pd = q0.paused; ef = q0.error_full;
         end else begin
            st = q1.state_o; cnt = q1.err_count; ini = q1.init; idl = q1.idle;
            ps = q1.pause_stb; cs = q1.continue_stb; pd = q1.paused; ef = q1.error_full;
         end
         chk($sformatf("model_m%0d_state", m), st, m_state[m]);
         chk($sformatf("model_m%0d_init", m), ini, m_init[m]);
         chk($sformatf("model_m%0d_idle", m), idl, m_idle[m]);
         chk($sformatf("model_m%0d_pause_stb", m), ps, m_pstb[m]);
         chk($sformatf("model_m%0d_continue_stb", m), cs, m_cstb[m]);
         chk($sformatf("model_m%0d_paused", m), pd, m_paused[m]);
         chk($sformatf("model_m%0d_error_full", m), ef, m_ef[m]);
         chk($sformatf("model_m%0d_err_count", m), cnt, m_cnt[m]);
      end
   endtask

   task automatic tick();
      drive();
      @(posedge CLK);
      model_edge(0);
      model_edge(1);
      #1;
      check_models();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      si = 1'b0; ec = 1'b0; emp = 4'hF; ful = 4'h0; pf = 4'h0; cf = 4'h0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      //             si  emp   ful   pf    cf    st ini idl ps    cs    pd    ef    cnt
      tbl[0]  = mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      tbl[1]  = mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      tbl[2]  = mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      tbl[3]  = mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 2, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      tbl[4]  = mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 2, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      tbl[5]  = mk(0, 4'hE, 4'h0, 4'h0, 4'h0, 3, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      tbl[6]  = mk(0, 4'hE, 4'h0, 4'h5, 4'h0, 3, 0, 0, 4'h5, 4'h0, 4'h5, 4'h0, 0);
      tbl[7]  = mk(0, 4'hE, 4'h0, 4'h5, 4'h0, 3, 0, 0, 4'h0, 4'h0, 4'h5, 4'h0, 0);
      tbl[8]  = mk(0, 4'hE, 4'h0, 4'h5, 4'h0, 3, 0, 0, 4'h0, 4'h0, 4'h5, 4'h0, 0);
      tbl[9]  = mk(0, 4'hE, 4'h0, 4'h5, 4'h0, 3, 0, 0, 4'h0, 4'h0, 4'h5, 4'h0, 0);
      tbl[10] = mk(0, 4'hE, 4'h0, 4'h5, 4'h0, 3, 0, 0, 4'h0, 4'h0, 4'h5, 4'h0, 0);
      tbl[11] = mk(0, 4'hE, 4'h0, 4'h5, 4'h1, 3, 0, 0, 4'h0, 4'h1, 4'h4, 4'h0, 0);
      tbl[12] = mk(0, 4'hE, 4'h0, 4'h5, 4'h1, 3, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0, 0);
      tbl[13] = mk(0, 4'hE, 4'h0, 4'h1, 4'h0, 3, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0, 0);
      tbl[14] = mk(0, 4'hE, 4'h0, 4'h5, 4'h6, 3, 0, 0, 4'h4, 4'h2, 4'h4, 4'h0, 0);
      tbl[15] = mk(0, 4'hE, 4'h8, 4'h7, 4'h6, 4, 0, 0, 4'h0, 4'h0, 4'h4, 4'h8, 1);
      tbl[16] = mk(0, 4'hE, 4'h2, 4'h7, 4'h6, 4, 0, 0, 4'h0, 4'h0, 4'h4, 4'hA, 1);
      tbl[17] = mk(0, 4'hE, 4'h0, 4'h7, 4'h6, 4, 0, 0, 4'h0, 4'h0, 4'h4, 4'hA, 1);

      // reset state
      reset = 1'b1;
      si = 1'b1; ec = 1'b0; emp = 4'hF; ful = 4'h0; pf = 4'h0; cf = 4'h0;
      tick();
      tick();
      chk("rst_state", q1.state_o, 3'd0);
      chk("rst_err_count", q1.err_count, 3'd0);
      chk("rst_paused", q1.paused, 4'h0);
      reset = 1'b0;

      // directed vectors applied to both instances
      for (int r = 0; r < 18; r++) begin
         si = tbl[r].si; emp = tbl[r].emp; ful = tbl[r].ful; pf = tbl[r].pf; cf = tbl[r].cf;
         tick();
         chk($sformatf("vec%0d_state", r), q1.state_o, tbl[r].st);
         chk($sformatf("vec%0d_init", r), q1.init, tbl[r].ini);
         chk($sformatf("vec%0d_idle", r), q1.idle, tbl[r].idl);
         chk($sformatf("vec%0d_pause_stb", r), q1.pause_stb, tbl[r].ps);
         chk($sformatf("vec%0d_continue_stb", r), q1.continue_stb, tbl[r].cs);
         chk($sformatf("vec%0d_paused", r), q1.paused, tbl[r].pd);
         chk($sformatf("vec%0d_error_full", r), q1.error_full, tbl[r].ef);
         chk($sformatf("vec%0d_err_count", r), q1.err_count, tbl[r].cnt);
         chk($sformatf("vec%0d_m0_state", r), q0.state_o, tbl[r].st);
      end

      // error_clear: mode 1 recovers to IDLE, mode 0 stays in ERROR
      ful = 4'h0; ec = 1'b1;
      tick();
      chk("clr_m1_state", q1.state_o, 3'd2);
      chk("clr_m1_error_full", q1.error_full, 4'h0);
      chk("clr_m1_paused", q1.paused, 4'h0);
      chk("clr_m1_err_count", q1.err_count, 3'd1);
      chk("clr_m0_state", q0.state_o, 3'd4);
      chk("clr_m0_error_full", q0.error_full, 4'hA);
      ec = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("clr_m0_hold_state", q0.state_o, 3'd4);
      end

      // idle timeout, then timeout restarted by a pause edge at cycle 10
      do_reset();
      chk("to_rst_state", q1.state_o, 3'd0);
      tick();
      tick();
      emp = 4'hE;
      tick();
      chk("to_enter_active", q1.state_o, 3'd3);
      emp = 4'hF;
      for (int k = 1; k <= TO; k++) begin
         tick();
         chk($sformatf("to_a_k%0d", k), q1.state_o, (k < TO) ? 3'd3 : 3'd2);
      end
      emp = 4'hE;
      tick();
      emp = 4'hF;
      for (int k = 1; k <= 26; k++) begin
         if (k == 10) pf = 4'h1;
         tick();
         if (k == 10) chk("to_b_pause_stb", q1.pause_stb, 4'h1);
         chk($sformatf("to_b_k%0d", k), q1.state_o, (k < 26) ? 3'd3 : 3'd2);
      end

      // err_count saturation in mode 1
      do_reset();
      pf = 4'h0;
      tick();
      tick();
      for (int it = 1; it <= 9; it++) begin
         emp = 4'hE; ful = 4'h0; ec = 1'b0;
         tick();
         ful = 4'h1;
         tick();
         chk($sformatf("sat_it%0d", it), q1.err_count, (it < 7) ? it : 7);
         ful = 4'h0; ec = 1'b1;
         tick();
      end
      ec = 1'b0;

      // randomized stimulus against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         si    = ($urandom_range(0, 15) == 0);
         emp   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
         ful   = ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
         if ($urandom_range(0, 2) == 0) pf[$urandom_range(0, 3)] = ~pf[$urandom_range(0, 3)];
         if ($urandom_range(0, 2) == 0) cf = cf ^ 4'(1 << $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) pf = pf ^ 4'(1 << $urandom_range(0, 3));
         ec    = ($urandom_range(0, 7) == 0);
         tick();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
